// File: rtl/axis_pkg.sv
// Shared AXI-Stream lane definitions for the kernel datapath pack/unpack stages.
// Both ends import these defaults so the lane count and lane width always agree.
package axis_pkg;

  localparam int unsigned KERNEL_SIZE_DEF = 3;
  localparam int unsigned DATA_WIDTH_DEF  = 8;

  // Bit offset of lane idx inside a packed multi-lane word.
  function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned dw);
    return idx * dw;
  endfunction

endpackage

// File: rtl/fifo_axis.sv
// Single-lane AXI-Stream FIFO with first-word-fall-through head.
// Ports:
//   clk, rstn           clock, async active-low reset
//   s_tdata/s_tvalid    write side; s_tready = not full (combinational)
//   m_tdata/m_tvalid    head word and non-empty flag (combinational from state)
//   m_tready            pop request; ignored while empty
module fifo_axis #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready
);

  localparam int unsigned CNT_W = PTR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push     = s_tvalid && !full;
  assign pop      = m_tready && !empty;
  assign s_tready = !full;
  assign m_tvalid = !empty;
  assign m_tdata  = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

endmodule

// File: rtl/axis_pack_data.sv
// Packs KERNEL_SIZE independent narrow AXI-Stream lanes into one wide beat.
// Each lane is buffered in its own fifo_axis; a wide beat is registered only
// when every lane holds a word, and all lanes pop together.
// Ports:
//   clk, rstn       clock, async active-low reset
//   s_axis_*        per-lane inputs; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_*        registered wide output; tlast marks beat ROW_LEN-1 of a row
module axis_pack_data
  import axis_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PTR_WIDTH   = 2,
  parameter int unsigned ROW_LEN     = 4,
  parameter int unsigned CNT_WIDTH   = 2
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KERNEL_SIZE-1:0]            s_axis_tvalid,
  output logic [KERNEL_SIZE-1:0]            s_axis_tready,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
);

  localparam int unsigned WORD_W = KERNEL_SIZE * DATA_WIDTH;

  logic [WORD_W-1:0]      head_word;
  logic [KERNEL_SIZE-1:0] lane_nonempty;
  logic                   all_valid;
  logic                   load;
  logic                   row_end;
  logic [CNT_WIDTH-1:0]   beat_cnt;

  // One FIFO per lane; every FIFO pops on the shared load strobe.
  for (genvar i = 0; i < int'(KERNEL_SIZE); i++) begin : g_lane
    fifo_axis #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_WIDTH  (PTR_WIDTH)
    ) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .s_tdata  (s_axis_tdata[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .s_tvalid (s_axis_tvalid[i]),
      .s_tready (s_axis_tready[i]),
      .m_tdata  (head_word[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .m_tvalid (lane_nonempty[i]),
      .m_tready (load)
    );
  end

  // Join: load when every lane has a head and the output register is free.
  assign all_valid = &lane_nonempty;
  assign load      = all_valid && (!m_axis_tvalid || m_axis_tready);
  assign row_end   = (beat_cnt == CNT_WIDTH'(ROW_LEN - 1));

  // Output register and row beat counter; both advance only on load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      beat_cnt      <= '0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= head_word;
      m_axis_tlast  <= row_end;
      beat_cnt      <= row_end ? '0 : beat_cnt + CNT_WIDTH'(1);
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_pack_data.sv
// Scoreboard bench for axis_pack_data: accepted lane words feed per-lane
// reference queues; the k-th wide word is the k-th word of every lane, with
// tlast on every ROW_LEN-th word. A monitor compares each output handshake.
module tb_axis_pack_data;

  localparam int unsigned KS = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned RL = 4;
  localparam int unsigned WW = KS * DW;

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk;
  logic          rstn;
  logic [WW-1:0] s_axis_tdata;
  logic [KS-1:0] s_axis_tvalid;
  logic [KS-1:0] s_axis_tready;
  logic [WW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;

  axis_pack_data #(
    .KERNEL_SIZE (KS),
    .DATA_WIDTH  (DW),
    .DEPTH       (4),
    .PTR_WIDTH   (2),
    .ROW_LEN     (RL),
    .CNT_WIDTH   (2)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [DW-1:0] lane_q [KS][$];
  exp_t          exp_q [$];
  int            exp_idx = 0;
  int            hs_idx  = 0;
  logic [7:0]    tlast_mask = '0;
  logic          prev_hold = 1'b0;
  logic [WW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit lanes_ready();
    for (int i = 0; i < int'(KS); i++)
      if (lane_q[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor: samples mid-cycle, i.e. the values the next rising edge will act on.
  always @(negedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(KS); i++) lane_q[i].delete();
      exp_q.delete();
      exp_idx    = 0;
      hs_idx     = 0;
      tlast_mask = '0;
      prev_hold  = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'd1);
        check("hold_data", 64'(m_axis_tdata), 64'(prev_data));
        check("hold_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      for (int i = 0; i < int'(KS); i++)
        if (s_axis_tvalid[i] && s_axis_tready[i])
          lane_q[i].push_back(s_axis_tdata[i*DW +: DW]);
      while (lanes_ready()) begin
        exp_t e;
        e.data = '0;
        for (int i = 0; i < int'(KS); i++) e.data[i*DW +: DW] = lane_q[i].pop_front();
        e.last = ((exp_idx % RL) == (RL - 1));
        exp_q.push_back(e);
        exp_idx++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL spurious_beat: got %0h expected no beat at %0t", m_axis_tdata, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("beat_data", 64'(m_axis_tdata), 64'(e.data));
          check("beat_last", 64'(m_axis_tlast), 64'(e.last));
        end
        if (hs_idx < 8) tlast_mask[hs_idx] = m_axis_tlast;
        hs_idx++;
      end
      prev_hold = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
    end
  end

  // Advance to just after the next rising edge, where inputs may change.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [DW-1:0] d);
    s_axis_tdata[i*DW +: DW] = d;
    s_axis_tvalid[i]         = 1'b1;
  endtask

  task automatic do_reset();
    cyc();
    rstn = 1'b0;
    s_axis_tvalid = '0;
    cyc();
    cyc();
    rstn = 1'b1;
  endtask

  initial begin
    rstn          = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    m_axis_tready = 1'b0;

    // Reset / idle
    repeat (3) cyc();
    @(negedge clk);
    check("rst_tready", 64'(s_axis_tready), 64'h7);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    cyc();
    rstn = 1'b1;
    cyc();

    // Aligned packing: two-cycle latency
    m_axis_tready = 1'b1;
    set_lane(0, 8'h11); set_lane(1, 8'h22); set_lane(2, 8'h33);
    cyc();
    s_axis_tvalid = '0;
    @(negedge clk);
    check("align_lat1_valid", 64'(m_axis_tvalid), 64'd0);
    cyc();
    @(negedge clk);
    check("align_valid", 64'(m_axis_tvalid), 64'd1);
    check("align_data", 64'(m_axis_tdata), 64'h332211);
    check("align_last", 64'(m_axis_tlast), 64'd0);

    // Skewed lanes
    for (int c = 0; c <= 8; c++) begin
      cyc();
      s_axis_tvalid = '0;
      if (c == 0) set_lane(0, 8'hA0);
      if (c == 3) set_lane(1, 8'hB0);
      if (c == 6) set_lane(2, 8'hC0);
      @(negedge clk);
      if (c < 8) check("skew_wait_valid", 64'(m_axis_tvalid), 64'd0);
      else begin
        check("skew_valid", 64'(m_axis_tvalid), 64'd1);
        check("skew_data", 64'(m_axis_tdata), 64'hC0B0A0);
      end
    end

    // Backpressure: fill lane 0 only, then complete one word while stalled
    cyc();
    s_axis_tvalid = '0;
    m_axis_tready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      s_axis_tvalid = '0;
      set_lane(0, 8'(8'h40 + c));
    end
    cyc();
    s_axis_tvalid = '0;
    @(negedge clk);
    check("full_tready", 64'(s_axis_tready), 64'h6);
    check("full_no_valid", 64'(m_axis_tvalid), 64'd0);
    cyc();
    set_lane(1, 8'h51); set_lane(2, 8'h61);
    cyc();
    s_axis_tvalid = '0;
    @(negedge clk);
    check("bp_wait_valid", 64'(m_axis_tvalid), 64'd0);
    cyc();
    @(negedge clk);
    check("bp_valid", 64'(m_axis_tvalid), 64'd1);
    check("bp_data", 64'(m_axis_tdata), 64'h615140);
    check("bp_ready_back", 64'(s_axis_tready), 64'h7);
    repeat (3) cyc();
    m_axis_tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_lane(1, 8'(8'h52 + c)); set_lane(2, 8'(8'h62 + c));
      s_axis_tvalid[0] = 1'b0;
      cyc();
    end
    s_axis_tvalid = '0;
    repeat (6) cyc();

    // Randomised traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      s_axis_tvalid = KS'($urandom);
      s_axis_tdata  = WW'($urandom);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    s_axis_tvalid = '0;
    m_axis_tready = 1'b1;
    repeat (12) cyc();
    @(negedge clk);
    check("drain_pending", 64'(exp_q.size()), 64'd0);

    // Mid-stream reset with buffered and registered data
    do_reset();
    m_axis_tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 8'(8'h70 + c)); set_lane(1, 8'(8'h80 + c)); set_lane(2, 8'(8'h90 + c));
      cyc();
    end
    s_axis_tvalid = '0;
    cyc();
    @(negedge clk);
    check("pre_rst_valid", 64'(m_axis_tvalid), 64'd1);
    cyc();
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
    check("mid_rst_data", 64'(m_axis_tdata), 64'd0);
    check("mid_rst_last", 64'(m_axis_tlast), 64'd0);
    check("mid_rst_tready", 64'(s_axis_tready), 64'h7);
    cyc();
    cyc();
    rstn = 1'b1;
    cyc();

    // tlast framing: 8 beats, beat 2 stalled for two cycles
    for (int c = 0; c < 14; c++) begin
      s_axis_tvalid = '0;
      if (c < 8) begin
        set_lane(0, 8'(8'h10 + c)); set_lane(1, 8'(8'h20 + c)); set_lane(2, 8'(8'h30 + c));
      end
      m_axis_tready = !(c == 4 || c == 5);
      cyc();
    end
    s_axis_tvalid = '0;
    @(negedge clk);
    check("frame_beats", 64'(hs_idx), 64'd8);
    check("frame_tlast_mask", 64'(tlast_mask), 64'h88);
    check("frame_pending", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/axis_pack_data.md
Name: axis_pack_data

Overview:
- Gathers KERNEL_SIZE independent narrow AXI-Stream lanes into one wide AXI-Stream word. This is the inverse of the lane-splitting stage on the input side of the kernel datapath.
- Each lane is buffered in its own FIFO. A wide beat is emitted only when every lane holds data.
- A registered output stage drives the wide stream. A beat counter marks row ends with tlast.

Parameters:
- KERNEL_SIZE, 3, number of input lanes.
- DATA_WIDTH, 8, width of each lane word.
- DEPTH, 4, entries per lane FIFO (power of two).
- PTR_WIDTH, 2, log2(DEPTH).
- ROW_LEN, 4, wide beats per row; tlast is asserted on beat ROW_LEN-1 (ROW_LEN >= 1).
- CNT_WIDTH, 2, width of the beat counter; must satisfy 2^CNT_WIDTH >= ROW_LEN.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- s_axis_tdata  input  KERNEL_SIZE*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  input  KERNEL_SIZE  per-lane valid.
- s_axis_tready  output  KERNEL_SIZE  per-lane ready.
- m_axis_tdata  output  KERNEL_SIZE*DATA_WIDTH  packed word; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tvalid  output  1  packed word valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  last beat of a row.

Behaviour:
- Reset (async assert, sync release):
  - All lane FIFOs empty; pointers and counts are 0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, beat counter=0.
  - s_axis_tready = all ones, since the FIFOs are empty.
  - Reset asserted mid-operation discards all buffered and in-flight data with no partial beat.
- Lane input:
  - s_axis_tready[i] = !full[i], purely combinational from FIFO state.
  - Lane i pushes on s_axis_tvalid[i] && s_axis_tready[i].
  - Lanes are fully independent; one full lane never stalls another.
- Lane FIFO:
  - A word written at edge t is visible at the FIFO head after edge t, i.e. it can be popped at edge t+1.
  - A full FIFO accepts no push, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- Join:
  - all_valid = AND of the lane FIFO non-empty flags.
  - load = all_valid && (!m_axis_tvalid || m_axis_tready).
  - On load, every FIFO pops exactly one word in the same cycle and the heads are registered into m_axis_tdata. A lane is never popped alone.
- Output register:
  - m_axis_tvalid sets on load.
  - It clears on m_axis_tready when there is no load in the same cycle.
  - m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid && !m_axis_tready.
- Latency and throughput:
  - Last lane push at edge t gives m_axis_tvalid=1 after edge t+1 (2 cycles).
  - Sustains 1 wide beat/cycle when all lanes stream and m_axis_tready=1.
- Beat counter:
  - On load, m_axis_tlast <= (cnt == ROW_LEN-1).
  - cnt <= (cnt == ROW_LEN-1) ? 0 : cnt+1.
  - The counter advances only on load, never on stall cycles.

Decomposition:
- Shared package axis_pkg holds:
  - the lane-slice helper (index i -> bit offset i*DATA_WIDTH);
  - default KERNEL_SIZE and DATA_WIDTH constants, shared with the unpack side so both ends agree.
- One sub-module is natural: the existing fifo_axis, instantiated KERNEL_SIZE times in a generate loop.
  - Its m_tvalid is the lane non-empty flag.
  - Its m_tready is driven by load.
- The join logic, output register and beat counter live in the top level.

Test Plan:
- Reset/idle: hold rstn=0, then release with no input → s_axis_tready=3'b111, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
- Aligned packing: at edge t push lanes 0,1,2 with 0x11,0x22,0x33 simultaneously → after edge t+1, m_axis_tdata=0x332211, m_axis_tvalid=1, m_axis_tlast=0.
- Skewed lanes: push lane0=0xA0 at cycle 0, lane1=0xB0 at cycle 3, lane2=0xC0 at cycle 6 → m_axis_tvalid=0 until after edge 7, then word 0xC0B0A0.
- Backpressure/full:
  - Push 4 words into lane 0 only (DEPTH=4) → s_axis_tready[0]=0 while lanes 1,2 stay 1, and m_axis_tvalid stays 0.
  - Then fill lanes 1,2 with m_axis_tready=0 → one word is registered and held stable; lane 0 count drops to 3 and ready returns.
- tlast framing: stream 8 aligned beats with m_axis_tready=1 → m_axis_tlast=1 on beats 3 and 7 only.
  - Insert m_axis_tready=0 for 2 cycles at beat 2 → tlast still lands on beats 3 and 7, and beat 2 is held.
- Mid-stream reset: assert rstn=0 with 2 words in each FIFO and m_axis_tvalid=1 → all outputs return immediately to reset values; after release, the first aligned push yields tlast on the 4th beat.
